// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall / flush / freeze controller for the 5-stage ARM pipeline.
//   - Detects RAW hazards between the ID source registers and the EXE/MEM
//     destinations (load-use only when a forwarding unit is present).
//   - Sequences branch flushes for FLUSH_CYCLES cycles per taken branch.
//   - Freezes every pipeline register while a multi-cycle data-memory access
//     is outstanding, aborting with a sticky mem_error after MEM_TIMEOUT
//     frozen cycles.
//
// Parameters
//   FORWARDING    1: forwarding present, stall only on load-use; 0: any RAW
//   FLUSH_CYCLES  cycles flush stays high per taken branch (1..15)
//   MEM_TIMEOUT   max frozen cycles before a memory access is aborted (1..255)
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   id_src1/id_src2          ID operands; id_two_src qualifies id_src2
//   id_ignore_haz            ID instruction reads no registers
//   exe_dest/exe_wb_en       EXE destination and write-back enable
//   exe_mem_r_en             EXE instruction is a load
//   mem_dest/mem_wb_en       MEM destination and write-back enable
//   branch_taken             EXE resolved a taken branch
//   mem_req/mem_ready        data-memory access request / completion
//   hazard/flush/freeze      pipeline control (priority freeze > flush > hazard)
//   mem_error                sticky memory-timeout flag
//   state                    FSM state for debug (RUN=0, MEM_WAIT=1, FLUSH=2)
//   stall_cnt                saturating count of hazard|freeze cycles
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int FORWARDING   = 0,
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_src1,
    input  logic [3:0]  id_src2,
    input  logic        id_two_src,
    input  logic        id_ignore_haz,
    input  logic [3:0]  exe_dest,
    input  logic        exe_wb_en,
    input  logic        exe_mem_r_en,
    input  logic [3:0]  mem_dest,
    input  logic        mem_wb_en,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        hazard,
    output logic        flush,
    output logic        freeze,
    output logic        mem_error,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic        mem_error_q, mem_error_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic match1, match2, raw;
    logic timeout_hit;

    // RAW detection. With forwarding, only a load in EXE cannot be bypassed
    // in time, so that is the only case that needs a bubble.
    always_comb begin
        match1 = 1'b0;
        match2 = 1'b0;
        if (FORWARDING != 0) begin
            match1 = exe_wb_en & exe_mem_r_en & (exe_dest == id_src1);
            match2 = exe_wb_en & exe_mem_r_en & (exe_dest == id_src2) & id_two_src;
        end else begin
            match1 = (exe_wb_en & (exe_dest == id_src1)) |
                     (mem_wb_en & (mem_dest == id_src1));
            match2 = ((exe_wb_en & (exe_dest == id_src2)) |
                      (mem_wb_en & (mem_dest == id_src2))) & id_two_src;
        end
        raw = (match1 | match2) & ~id_ignore_haz;
    end

    // wait_cnt counts frozen cycles already spent on the current access, so
    // reaching MEM_TIMEOUT means the budget is used up and this cycle must
    // not freeze any more.
    assign timeout_hit = (wait_cnt_q == 8'(MEM_TIMEOUT));

    // Next-state and output logic. freeze is evaluated first; a taken branch
    // that coincides with a stalled access stays in EXE and is flushed once
    // the pipeline is released (deferred flush).
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        flush_cnt_d = flush_cnt_q;
        mem_error_d = mem_error_q;
        freeze      = 1'b0;
        flush       = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_req & ~mem_ready) begin
                    freeze     = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end else if (branch_taken) begin
                    flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = 4'(FLUSH_CYCLES - 1);
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = ST_RUN;
                end else if (timeout_hit) begin
                    state_d     = ST_RUN;
                    mem_error_d = 1'b1;
                end else begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            // flush_cnt holds the flush cycles still owed including this one;
            // branch_taken and mem_req are meaningless here and are ignored.
            ST_FLUSH: begin
                flush = 1'b1;
                if (flush_cnt_q <= 4'd1) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        hazard = ~freeze & ~flush & raw;

        stall_cnt_d = stall_cnt_q;
        if ((hazard | freeze) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 8'd0;
            flush_cnt_q <= 4'd0;
            mem_error_q <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mem_error_q <= mem_error_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign state     = state_q;
    assign mem_error = mem_error_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Two controller instances share one set of inputs:
//   dut_a: FORWARDING=0, FLUSH_CYCLES=3, MEM_TIMEOUT=8
//   dut_b: FORWARDING=1, FLUSH_CYCLES=1, MEM_TIMEOUT=255
// Directed scenarios compare against hand-derived constants; the random
// scenario compares every cycle against a behavioural model that tracks
// "flush cycles still owed", "access outstanding / cycles frozen so far",
// the sticky error and the stall tally.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
    logic       id_two_src, id_ignore_haz, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic       branch_taken, mem_req, mem_ready;

    logic        hazard_a, flush_a, freeze_a, mem_error_a;
    logic [1:0]  state_a;
    logic [15:0] stall_cnt_a;
    logic        hazard_b, flush_b, freeze_b, mem_error_b;
    logic [1:0]  state_b;
    logic [15:0] stall_cnt_b;

    int checks   = 0;
    int failures = 0;

    pipeline_hazard_ctrl #(.FORWARDING(0), .FLUSH_CYCLES(3), .MEM_TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .id_ignore_haz(id_ignore_haz), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .hazard(hazard_a), .flush(flush_a), .freeze(freeze_a),
        .mem_error(mem_error_a), .state(state_a), .stall_cnt(stall_cnt_a)
    );

    pipeline_hazard_ctrl #(.FORWARDING(1), .FLUSH_CYCLES(1), .MEM_TIMEOUT(255)) dut_b (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .id_ignore_haz(id_ignore_haz), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .hazard(hazard_b), .flush(flush_b), .freeze(freeze_b),
        .mem_error(mem_error_b), .state(state_b), .stall_cnt(stall_cnt_b)
    );

    // Behavioural model state, one slot per instance.
    int m_flush_left[2];
    int m_busy[2];
    int m_frozen[2];
    int m_err[2];
    int m_stalls[2];
    int n_flush_left[2];
    int n_busy[2];
    int n_frozen[2];
    int n_err[2];
    int n_stalls[2];
    bit e_hazard[2];
    bit e_flush[2];
    bit e_freeze[2];
    int e_state[2];

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_flush_left[i] = 0;
            m_busy[i]       = 0;
            m_frozen[i]     = 0;
            m_err[i]        = 0;
            m_stalls[i]     = 0;
        end
    endtask

    // Expected outputs for the current inputs plus the model's next state.
    task automatic model_eval();
        for (int i = 0; i < 2; i++) begin
            int fwd, fc, mt;
            bit hit1, hit2, raw, fz, fl;
            fwd = (i == 0) ? 0 : 1;
            fc  = (i == 0) ? 3 : 1;
            mt  = (i == 0) ? 8 : 255;
            if (fwd == 0) begin
                hit1 = (exe_wb_en && exe_dest == id_src1) || (mem_wb_en && mem_dest == id_src1);
                hit2 = id_two_src &&
                       ((exe_wb_en && exe_dest == id_src2) || (mem_wb_en && mem_dest == id_src2));
            end else begin
                hit1 = exe_wb_en && exe_mem_r_en && exe_dest == id_src1;
                hit2 = id_two_src && exe_wb_en && exe_mem_r_en && exe_dest == id_src2;
            end
            raw = (hit1 || hit2) && !id_ignore_haz;
            fz = 1'b0;
            fl = 1'b0;
            n_flush_left[i] = m_flush_left[i];
            n_busy[i]       = m_busy[i];
            n_frozen[i]     = m_frozen[i];
            n_err[i]        = m_err[i];
            if (m_flush_left[i] > 0) begin
                fl = 1'b1;
                n_flush_left[i] = m_flush_left[i] - 1;
            end else if (m_busy[i] != 0) begin
                if (mem_ready) begin
                    n_busy[i] = 0;
                end else if (m_frozen[i] >= mt) begin
                    n_busy[i] = 0;
                    n_err[i]  = 1;
                end else begin
                    fz = 1'b1;
                    n_frozen[i] = m_frozen[i] + 1;
                end
            end else if (mem_req && !mem_ready) begin
                fz = 1'b1;
                n_busy[i]   = 1;
                n_frozen[i] = 1;
            end else if (branch_taken) begin
                fl = 1'b1;
                n_flush_left[i] = fc - 1;
            end
            e_freeze[i] = fz;
            e_flush[i]  = fl;
            e_hazard[i] = !fz && !fl && raw;
            n_stalls[i] = m_stalls[i];
            if ((e_hazard[i] || fz) && m_stalls[i] < 65535) n_stalls[i] = m_stalls[i] + 1;
            e_state[i] = (m_flush_left[i] > 0) ? 2 : ((m_busy[i] != 0) ? 1 : 0);
        end
    endtask

    function automatic logic [22:0] exp_vec(int i);
        logic [1:0]  st;
        logic [15:0] sc;
        st = 2'(e_state[i]);
        sc = 16'(m_stalls[i]);
        return {e_hazard[i], e_flush[i], e_freeze[i], (m_err[i] != 0), st, sc};
    endfunction

    task automatic tick();
        model_eval();
        @(posedge clk);
        if (rst == 1'b0) begin
            model_clear();
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_flush_left[i] = n_flush_left[i];
                m_busy[i]       = n_busy[i];
                m_frozen[i]     = n_frozen[i];
                m_err[i]        = n_err[i];
                m_stalls[i]     = n_stalls[i];
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0; id_ignore_haz = 1'b0;
        exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_dest = 4'd0; mem_wb_en = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic randomize_inputs();
        id_src1       = 4'($urandom_range(0, 3));
        id_src2       = 4'($urandom_range(0, 3));
        id_two_src    = 1'($urandom_range(0, 1));
        id_ignore_haz = ($urandom_range(0, 7) == 0);
        exe_dest      = 4'($urandom_range(0, 3));
        exe_wb_en     = 1'($urandom_range(0, 1));
        exe_mem_r_en  = 1'($urandom_range(0, 1));
        mem_dest      = 4'($urandom_range(0, 3));
        mem_wb_en     = 1'($urandom_range(0, 1));
        branch_taken  = ($urandom_range(0, 99) < 15);
        mem_req       = ($urandom_range(0, 99) < 30);
        mem_ready     = ($urandom_range(0, 99) < 25);
    endtask

    // Garbage inputs while reset is held must leave no trace afterwards.
    task automatic test_reset();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            randomize_inputs();
            mem_req = 1'b1;
            branch_taken = 1'b1;
            tick();
        end
        clear_inputs();
        rst = 1'b1;
        #1;
        checks++;
        if ({hazard_a, flush_a, freeze_a, mem_error_a, state_a, stall_cnt_a} !== 23'd0) begin
            failures++;
            $display("[TB] FAIL reset_a got=%h exp=0", {hazard_a, flush_a, freeze_a, mem_error_a, state_a, stall_cnt_a});
        end
        checks++;
        if ({hazard_b, flush_b, freeze_b, mem_error_b, state_b, stall_cnt_b} !== 23'd0) begin
            failures++;
            $display("[TB] FAIL reset_b got=%h exp=0", {hazard_b, flush_b, freeze_b, mem_error_b, state_b, stall_cnt_b});
        end
        tick();
    endtask

    task automatic test_raw_noforward();
        do_reset();
        exe_wb_en = 1'b1; exe_dest = 4'd3; id_src1 = 4'd3;
        #1;
        checks++;
        if (hazard_a !== 1'b1) begin failures++; $display("[TB] FAIL raw_exe_src1 hazard_a=%b exp=1", hazard_a); end
        checks++;
        if (hazard_b !== 1'b0) begin failures++; $display("[TB] FAIL fwd_no_load hazard_b=%b exp=0", hazard_b); end
        tick();
        id_ignore_haz = 1'b1;
        #1;
        checks++;
        if (hazard_a !== 1'b0) begin failures++; $display("[TB] FAIL raw_ignored hazard_a=%b exp=0", hazard_a); end
        tick();
        id_ignore_haz = 1'b0; exe_wb_en = 1'b0; mem_wb_en = 1'b1; mem_dest = 4'd3;
        #1;
        checks++;
        if (hazard_a !== 1'b1) begin failures++; $display("[TB] FAIL raw_mem_src1 hazard_a=%b exp=1", hazard_a); end
        tick();
        id_src1 = 4'd7; id_src2 = 4'd3; id_two_src = 1'b0;
        #1;
        checks++;
        if (hazard_a !== 1'b0) begin failures++; $display("[TB] FAIL src2_unqualified hazard_a=%b exp=0", hazard_a); end
        tick();
        id_two_src = 1'b1;
        #1;
        checks++;
        if (hazard_a !== 1'b1) begin failures++; $display("[TB] FAIL raw_mem_src2 hazard_a=%b exp=1", hazard_a); end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (stall_cnt_a !== 16'd3) begin failures++; $display("[TB] FAIL raw_stall_cnt stall_cnt_a=%0d exp=3", stall_cnt_a); end
    endtask

    task automatic test_load_use();
        do_reset();
        exe_dest = 4'd5; exe_wb_en = 1'b1; id_src1 = 4'd0; id_src2 = 4'd5; id_two_src = 1'b1;
        exe_mem_r_en = 1'b0;
        #1;
        checks++;
        if (hazard_b !== 1'b0) begin failures++; $display("[TB] FAIL fwd_alu_result hazard_b=%b exp=0", hazard_b); end
        checks++;
        if (hazard_a !== 1'b1) begin failures++; $display("[TB] FAIL nofwd_src2 hazard_a=%b exp=1", hazard_a); end
        tick();
        exe_mem_r_en = 1'b1;
        #1;
        checks++;
        if (hazard_b !== 1'b1) begin failures++; $display("[TB] FAIL load_use hazard_b=%b exp=1", hazard_b); end
        tick();
        exe_wb_en = 1'b0;
        #1;
        checks++;
        if (hazard_b !== 1'b0) begin failures++; $display("[TB] FAIL load_no_wb hazard_b=%b exp=0", hazard_b); end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (stall_cnt_b !== 16'd1) begin failures++; $display("[TB] FAIL load_stall_cnt stall_cnt_b=%0d exp=1", stall_cnt_b); end
    endtask

    // Raw inputs stay active the whole time so hazard masking is visible.
    task automatic test_flush();
        do_reset();
        exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd2; id_src1 = 4'd2;
        branch_taken = 1'b1;
        #1;
        checks++;
        if (flush_a !== 1'b1 || hazard_a !== 1'b0) begin
            failures++; $display("[TB] FAIL flush_c1_a flush=%b hazard=%b exp 1/0", flush_a, hazard_a);
        end
        checks++;
        if (flush_b !== 1'b1 || hazard_b !== 1'b0) begin
            failures++; $display("[TB] FAIL flush_c1_b flush=%b hazard=%b exp 1/0", flush_b, hazard_b);
        end
        tick();
        branch_taken = 1'b0;
        for (int k = 2; k <= 3; k++) begin
            #1;
            checks++;
            if (flush_a !== 1'b1 || hazard_a !== 1'b0) begin
                failures++; $display("[TB] FAIL flush_c%0d_a flush=%b hazard=%b exp 1/0", k, flush_a, hazard_a);
            end
            checks++;
            if (flush_b !== 1'b0 || hazard_b !== 1'b1) begin
                failures++; $display("[TB] FAIL flush_c%0d_b flush=%b hazard=%b exp 0/1", k, flush_b, hazard_b);
            end
            tick();
        end
        #1;
        checks++;
        if (flush_a !== 1'b0 || hazard_a !== 1'b1 || state_a !== 2'd0) begin
            failures++; $display("[TB] FAIL flush_end_a flush=%b hazard=%b state=%0d exp 0/1/0", flush_a, hazard_a, state_a);
        end
        tick();
    endtask

    task automatic test_mem_freeze();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++;
            if (freeze_a !== 1'b1 || freeze_b !== 1'b1) begin
                failures++; $display("[TB] FAIL freeze_c%0d a=%b b=%b exp 1/1", k, freeze_a, freeze_b);
            end
            tick();
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (freeze_a !== 1'b0 || freeze_b !== 1'b0) begin
            failures++; $display("[TB] FAIL freeze_ready a=%b b=%b exp 0/0", freeze_a, freeze_b);
        end
        tick();
        mem_req = 1'b0; mem_ready = 1'b0;
        #1;
        checks++;
        if (stall_cnt_a !== 16'd4 || state_a !== 2'd0) begin
            failures++; $display("[TB] FAIL freeze_after stall_cnt=%0d state=%0d exp 4/0", stall_cnt_a, state_a);
        end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            checks++;
            if (freeze_a !== 1'b1) begin failures++; $display("[TB] FAIL timeout_freeze_c%0d freeze_a=%b exp 1", k, freeze_a); end
            tick();
        end
        #1;
        checks++;
        if (freeze_a !== 1'b0 || freeze_b !== 1'b1) begin
            failures++; $display("[TB] FAIL timeout_drop a=%b b=%b exp 0/1", freeze_a, freeze_b);
        end
        tick();
        mem_req = 1'b0;
        #1;
        checks++;
        if (mem_error_a !== 1'b1 || state_a !== 2'd0 || mem_error_b !== 1'b0) begin
            failures++; $display("[TB] FAIL timeout_err err_a=%b state_a=%0d err_b=%b exp 1/0/0", mem_error_a, state_a, mem_error_b);
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        #1;
        checks++;
        if (mem_error_a !== 1'b1 || state_b !== 2'd0) begin
            failures++; $display("[TB] FAIL timeout_sticky err_a=%b state_b=%0d exp 1/0", mem_error_a, state_b);
        end
    endtask

    task automatic test_deferred_flush();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            #1;
            checks++;
            if (freeze_a !== 1'b1 || flush_a !== 1'b0 || freeze_b !== 1'b1 || flush_b !== 1'b0) begin
                failures++; $display("[TB] FAIL defer_frozen_c%0d fz_a=%b fl_a=%b fz_b=%b fl_b=%b exp 1/0/1/0",
                                     k, freeze_a, flush_a, freeze_b, flush_b);
            end
            tick();
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (freeze_a !== 1'b0 || flush_a !== 1'b0 || flush_b !== 1'b0) begin
            failures++; $display("[TB] FAIL defer_release fz_a=%b fl_a=%b fl_b=%b exp 0/0/0", freeze_a, flush_a, flush_b);
        end
        tick();
        mem_req = 1'b0; mem_ready = 1'b0;
        #1;
        checks++;
        if (flush_a !== 1'b1 || flush_b !== 1'b1) begin
            failures++; $display("[TB] FAIL defer_flush a=%b b=%b exp 1/1", flush_a, flush_b);
        end
        tick();
        branch_taken = 1'b0;
        #1;
        checks++;
        if (flush_b !== 1'b0 || flush_a !== 1'b1) begin
            failures++; $display("[TB] FAIL defer_after a=%b b=%b exp 1/0", flush_a, flush_b);
        end
        tick();
        tick();
        #1;
        checks++;
        if (flush_a !== 1'b0 || state_a !== 2'd0) begin
            failures++; $display("[TB] FAIL defer_end flush_a=%b state_a=%0d exp 0/0", flush_a, state_a);
        end
    endtask

    task automatic test_reset_midwait();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        #1;
        checks++;
        if (mem_error_a !== 1'b1 || state_a !== 2'd1) begin
            failures++; $display("[TB] FAIL midwait_pre err_a=%b state_a=%0d exp 1/1", mem_error_a, state_a);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        clear_inputs();
        #1;
        checks++;
        if ({hazard_a, flush_a, freeze_a, mem_error_a, state_a, stall_cnt_a} !== 23'd0) begin
            failures++; $display("[TB] FAIL midwait_reset_a got=%h exp=0", {hazard_a, flush_a, freeze_a, mem_error_a, state_a, stall_cnt_a});
        end
        checks++;
        if ({hazard_b, flush_b, freeze_b, mem_error_b, state_b, stall_cnt_b} !== 23'd0) begin
            failures++; $display("[TB] FAIL midwait_reset_b got=%h exp=0", {hazard_b, flush_b, freeze_b, mem_error_b, state_b, stall_cnt_b});
        end
        tick();
    endtask

    task automatic test_random();
        logic [22:0] obs;
        logic [22:0] exp;
        do_reset();
        for (int k = 0; k < 800; k++) begin
            randomize_inputs();
            rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            #1;
            model_eval();
            obs = {hazard_a, flush_a, freeze_a, mem_error_a, state_a, stall_cnt_a};
            exp = exp_vec(0);
            checks++;
            if (obs !== exp) begin
                failures++; $display("[TB] FAIL random_a cycle=%0d got=%h exp=%h", k, obs, exp);
            end
            obs = {hazard_b, flush_b, freeze_b, mem_error_b, state_b, stall_cnt_b};
            exp = exp_vec(1);
            checks++;
            if (obs !== exp) begin
                failures++; $display("[TB] FAIL random_b cycle=%0d got=%h exp=%h", k, obs, exp);
            end
            tick();
        end
        rst = 1'b1;
    endtask

    initial begin
        model_clear();
        clear_inputs();
        rst = 1'b0;
        test_reset();
        test_raw_noforward();
        test_load_use();
        test_flush();
        test_mem_freeze();
        test_timeout();
        test_deferred_flush();
        test_reset_midwait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
